// File: rtl/tt_sweep.sv
// tt_sweep: exhaustive truth-table sweeper for a small combinational function.
// Steps a 3- or 4-bit input vector through every row. Each row is held for
// SETTLE cycles, then the function output is sampled and compared against a
// golden table that was captured when the sweep started.
//
// Parameters
//   SETTLE         cycles each vector is held before sampling (1..15)
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active high
//   start          begin a sweep (accepted only when idle)
//   mode4          1: 16 rows (4-input), 0: 8 rows (3-input); captured on start
//   expected[15:0] golden truth table, bit i = row i; captured on start
//   f_in           output of the function under test
//   vec_out[3:0]   current input vector
//   busy           sweep in progress
//   done           one-cycle pulse at sweep completion
//   table_out      observed truth table
//   err_count      number of mismatching rows
//   first_err_idx  lowest mismatching row (0 if none)
//   mismatch       err_count is nonzero
//
// state  | meaning
// IDLE   | waiting for start; results held
// WAIT   | vector applied, settling for SETTLE cycles
// SAMPLE | capture f_in for the current row, advance or finish
// DONE   | one-cycle completion pulse
module tt_sweep #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode4,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic [3:0]  vec_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        mismatch
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [4:0] ERR_MAX   = 5'd16;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic        mode_q;
  logic [15:0] exp_q;
  logic        last_row;
  logic        row_err;

  assign last_row = mode_q ? (idx == 4'd15) : (idx == 4'd7);
  assign row_err  = (f_in != exp_q[idx]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_row ? DONE : WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Settle timer is a down-counter reloaded with SETTLE-1 on every new vector,
  // so WAIT occupies exactly SETTLE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= 4'd0;
      cnt           <= 4'd0;
      mode_q        <= 1'b0;
      exp_q         <= 16'd0;
      table_out     <= 16'd0;
      err_count     <= 5'd0;
      first_err_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx           <= 4'd0;
            cnt           <= SETTLE_M1;
            mode_q        <= mode4;
            exp_q         <= expected;
            table_out     <= 16'd0;
            err_count     <= 5'd0;
            first_err_idx <= 4'd0;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          table_out[idx] <= f_in;
          if (row_err) begin
            if (err_count != ERR_MAX) err_count <= err_count + 5'd1;
            if (err_count == 5'd0)    first_err_idx <= idx;
          end
          if (!last_row) begin
            idx <= idx + 4'd1;
            cnt <= SETTLE_M1;
          end
        end
        default: ;
      endcase
    end
  end

  // idx never exceeds 7 in 3-input mode, so vec_out[3] stays low there.
  assign vec_out  = idx;
  assign busy     = (state == WAIT) || (state == SAMPLE);
  assign done     = (state == DONE);
  assign mismatch = (err_count != 5'd0);

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the cycles each input vector is held before its result is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: request to begin a sweep; honoured only in IDLE.
REQ-005 SHALL have port mode4, input, 1 bit: 1 sweeps 16 rows (4-input function), 0 sweeps 8 rows (3-input function); captured on accepted start.
REQ-006 SHALL have port expected, input, 16 bits: golden truth table, bit i = required output for row i; captured on accepted start.
REQ-007 SHALL have port f_in, input, 1 bit: output of the combinational function under test driven by vec_out.
REQ-008 SHALL have port vec_out, output, 4 bits: current input vector; in 3-input mode bit 3 is always 0.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done is asserted.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse at sweep completion.
REQ-011 SHALL have port table_out, output, 16 bits: observed truth table, bit i = f_in sampled for row i.
REQ-012 SHALL have port err_count, output, 5 bits: number of rows where observed differs from expected.
REQ-013 SHALL have port first_err_idx, output, 4 bits: lowest row index that mismatched; 0 if none.
REQ-014 SHALL have port mismatch, output, 1 bit: high whenever err_count is nonzero.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT, SAMPLE and DONE.
REQ-016 IDLE + start: clear table_out, err_count and first_err_idx; set row index to 0 and vec_out to 0; latch mode4 and expected; go to WAIT.
REQ-017 WAIT SHALL last exactly SETTLE cycles with vec_out stable, then go to SAMPLE.
REQ-018 SAMPLE (one cycle) SHALL write f_in into table_out[idx].
REQ-019 In SAMPLE, if f_in differs from expected[idx], the block SHALL increment err_count, and SHALL load first_err_idx with idx if this is the first mismatch.
REQ-020 From SAMPLE, if idx is the last row (15 in 4-input mode, 7 in 3-input mode), the FSM SHALL go to DONE; otherwise it SHALL increment idx, drive vec_out = idx+1 and return to WAIT.
REQ-021 DONE SHALL last one cycle, assert done, deassert busy and return to IDLE.
REQ-022 Latency from the accepted-start edge to the done pulse SHALL be rows*(SETTLE+1) cycles, i.e. 32 for 4-input mode with SETTLE=1.
REQ-023 start asserted while not in IDLE SHALL be ignored; it SHALL NOT restart the sweep or alter captured mode4 or expected.
REQ-024 Changes to expected or mode4 during a sweep SHALL have no effect.
REQ-025 In 3-input mode, table_out[15:8] SHALL remain 0 and rows 8..15 SHALL never be driven.
REQ-026 Results (table_out, err_count, first_err_idx, mismatch) SHALL hold after done until the next accepted start or reset.
REQ-027 err_count SHALL saturate at 16 and SHALL never wrap.

Reset
REQ-028 With rst high at a clock edge, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-029 rst SHALL take priority over start at the same edge.
REQ-030 rst asserted mid-sweep SHALL abort the sweep with no done pulse and all results cleared.

Verification
REQ-031 mode4=1, expected=0x0F2A, f_in=(~a&~c&d)|(a&~b)|(~b&d) on vec_out={a,b,c,d}, SETTLE=1 -> done 32 cycles after start, table_out=0x0F2A, err_count=0, mismatch=0.
REQ-032 mode4=0, expected=0x003A, f_in=(~a&d)|(a&~b) on vec_out[2:0]={a,b,d} -> done after 16 cycles, table_out=0x003A, vec_out[3] always 0, err_count=0.
REQ-033 mode4=0, expected=0x003A, f_in stuck at 0 -> table_out=0x0000, err_count=4, first_err_idx=1, mismatch=1.
REQ-034 rst pulsed while vec_out=5 in a 4-input sweep -> the next cycle shows all outputs 0, busy=0, no done pulse; a fresh start completes normally.
REQ-035 start re-asserted at row 3 -> ignored, done still exactly 32 cycles after the original start; then start with SETTLE=3 in 4-input mode -> done after 64 cycles, with prior results cleared at the start edge.
